// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types for the RV64 memory stage
// Purpose: pipeline payloads (exec_data_t in, mem_data_t out), data-bus
//          request/response records and the access-size helpers used by
//          mem_access and mem_align.
package mem_access_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic   memread;
        logic   memwrite;
        logic   mem_unsigned;
        logic   misalign;
        msize_t msize;
    } ctl_t;

    typedef struct packed {
        ctl_t        ctl;
        logic [4:0]  dst;
        logic [31:0] instr;
        logic [63:0] aluout;
        logic [63:0] rd;
    } exec_data_t;

    typedef struct packed {
        ctl_t        ctl;
        logic [4:0]  dst;
        logic [31:0] instr;
        logic [63:0] result;
    } mem_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    // Byte-enable pattern of an access at lane 0.
    function automatic logic [7:0] size_mask(input msize_t s);
        case (s)
            MSIZE1:  return 8'h01;
            MSIZE2:  return 8'h03;
            MSIZE4:  return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // An access is aligned when its low address bits are zero for its size.
    function automatic logic is_misaligned(input msize_t s, input logic [2:0] a);
        case (s)
            MSIZE1:  return 1'b0;
            MSIZE2:  return a[0];
            MSIZE4:  return a[1:0] != 2'b00;
            default: return a != 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-lane alignment and load extension for the memory stage
// Purpose: purely combinational lane steering for one 64-bit data bus beat.
// Ports:
//   msize, addr_lo, is_unsigned   access size, address bits [2:0], zero-extend select
//   store_data, load_data         unshifted store value, raw bus read data
//   strobe, wdata                 byte enables and lane-shifted store data
//   rdata                         selected load lane, extended to 64 bits
//   misalign                      address not aligned to the access size
module mem_align
    import mem_access_pkg::*;
(
    input  msize_t      msize,
    input  logic [2:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [63:0] store_data,
    input  logic [63:0] load_data,
    output logic [7:0]  strobe,
    output logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        misalign
);

    logic [5:0]  shamt;
    logic [63:0] lane;

    assign shamt    = {addr_lo, 3'b000};
    assign strobe   = size_mask(msize) << addr_lo;
    assign wdata    = store_data << shamt;
    assign lane     = load_data >> shamt;
    assign misalign = is_misaligned(msize, addr_lo);

    always_comb begin
        case (msize)
            MSIZE1:  rdata = is_unsigned ? {56'd0, lane[7:0]}  : {{56{lane[7]}}, lane[7:0]};
            MSIZE2:  rdata = is_unsigned ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            MSIZE4:  rdata = is_unsigned ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            default: rdata = lane;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - RV64 memory stage: pass-through ops and single-beat dbus loads/stores
// Purpose: registers the execute payload, issues one dbus request per aligned
//          load/store, stalls upstream while it is outstanding and hands the
//          extended result to writeback.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid, dataE     execute payload and its valid
//   flush               squash the op before it produces a result
//   dreq, dresp         data bus request / response
//   stall               upstream must hold dataE
//   out_valid, dataM    writeback payload and its valid
//   err_timeout         one-cycle pulse when a transaction waits TIMEOUT cycles
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  exec_data_t dataE,
    input  logic       flush,
    output dbus_req_t  dreq,
    input  dbus_resp_t dresp,
    output logic       stall,
    output logic       out_valid,
    output mem_data_t  dataM,
    output logic       err_timeout
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]  state;
    exec_data_t  op;
    logic        discard;
    logic [31:0] wd;

    logic        busy, mem_op, accept, capture, done;
    msize_t      a_size;
    logic [2:0]  a_addr_lo;
    logic        a_unsigned;
    logic [7:0]  a_strobe;
    logic [63:0] a_wdata, a_rdata;
    logic        a_misalign;
    ctl_t        trap_ctl;
    mem_data_t   mem_result;

    assign busy    = state != IDLE;
    assign mem_op  = dataE.ctl.memread | dataE.ctl.memwrite;
    assign accept  = !busy && in_valid && !flush;
    assign capture = accept && mem_op && !a_misalign;
    assign stall   = busy || capture;
    assign done    = (state == REQ && dresp.addr_ok && dresp.data_ok) ||
                     (state != IDLE && state != REQ && dresp.data_ok);

    // While idle the aligner judges the incoming op (misalign check); once a
    // transaction is open it only ever sees the captured op, so dreq stays stable.
    assign a_size     = busy ? op.ctl.msize        : dataE.ctl.msize;
    assign a_addr_lo  = busy ? op.aluout[2:0]      : dataE.aluout[2:0];
    assign a_unsigned = busy ? op.ctl.mem_unsigned : dataE.ctl.mem_unsigned;

    mem_align u_align (
        .msize       (a_size),
        .addr_lo     (a_addr_lo),
        .is_unsigned (a_unsigned),
        .store_data  (op.rd),
        .load_data   (dresp.data),
        .strobe      (a_strobe),
        .wdata       (a_wdata),
        .rdata       (a_rdata),
        .misalign    (a_misalign)
    );

    // The request is a pure function of state and the captured op.
    always_comb begin
        dreq = '0;
        if (busy) begin
            dreq.valid = 1'b1;
            dreq.addr  = op.aluout;
            dreq.size  = op.ctl.msize;
            if (op.ctl.memwrite) begin
                dreq.strobe = a_strobe;
                dreq.data   = a_wdata;
            end
        end
    end

    always_comb begin
        mem_result       = '0;
        mem_result.ctl   = op.ctl;
        mem_result.instr = op.instr;
        // Stores write nothing back: result and dst stay zero.
        if (op.ctl.memread) begin
            mem_result.dst    = op.dst;
            mem_result.result = a_rdata;
        end
        trap_ctl          = dataE.ctl;
        trap_ctl.misalign = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op          <= '0;
            discard     <= 1'b0;
            wd          <= '0;
            out_valid   <= 1'b0;
            dataM       <= '0;
            err_timeout <= 1'b0;
        end else begin
            out_valid   <= 1'b0;
            err_timeout <= 1'b0;

            // Watchdog saturates at TIMEOUT so it fires only once per transaction.
            if (busy && TIMEOUT != 32'd0 && wd != TIMEOUT) begin
                wd          <= wd + 32'd1;
                err_timeout <= (wd + 32'd1 == TIMEOUT);
            end

            case (state)
                IDLE: begin
                    wd      <= '0;
                    discard <= 1'b0;
                    if (accept) begin
                        if (!mem_op) begin
                            out_valid <= 1'b1;
                            dataM     <= '{ctl: dataE.ctl, dst: dataE.dst,
                                           instr: dataE.instr, result: dataE.aluout};
                        end else if (a_misalign) begin
                            out_valid <= 1'b1;
                            dataM     <= '{ctl: trap_ctl, dst: dataE.dst,
                                           instr: dataE.instr, result: 64'd0};
                        end else begin
                            op    <= dataE;
                            state <= REQ;
                        end
                    end
                end
                default: begin
                    if (state == REQ && !dresp.addr_ok) begin
                        // Not yet accepted by the bus, so a flush can withdraw it.
                        if (flush) begin
                            state <= IDLE;
                        end
                    end else if (done) begin
                        state <= IDLE;
                        if (!(discard || flush)) begin
                            out_valid <= 1'b1;
                            dataM     <= mem_result;
                        end
                    end else begin
                        // Accepted: must drain, but a flush marks the result for discard.
                        state   <= WAIT;
                        discard <= discard || flush;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench for mem_access
module tb_mem_access;
    import mem_access_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    exec_data_t dataE;
    logic       flush;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    logic       stall;
    logic       out_valid;
    mem_data_t  dataM;
    logic       err_timeout;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int        stall_cnt;
        int        dreq_cnt;
        int        out_cnt;
        int        out_cyc;
        int        err_cnt;
        int        err_cyc;
        logic      held_ok;
        dbus_req_t first_req;
        mem_data_t outd;
    } obs_t;

    mem_access #(.TIMEOUT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .dataE       (dataE),
        .flush       (flush),
        .dreq        (dreq),
        .dresp       (dresp),
        .stall       (stall),
        .out_valid   (out_valid),
        .dataM       (dataM),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    function automatic exec_data_t mk(input logic rd_op, input logic wr_op, input logic uns,
                                      input msize_t sz, input logic [4:0] dst,
                                      input logic [63:0] addr, input logic [63:0] rdv);
        exec_data_t e;
        e                  = '0;
        e.ctl.memread      = rd_op;
        e.ctl.memwrite     = wr_op;
        e.ctl.mem_unsigned = uns;
        e.ctl.msize        = sz;
        e.dst              = dst;
        e.instr            = 32'h00A0_0003 ^ {27'd0, dst};
        e.aluout           = addr;
        e.rd               = rdv;
        return e;
    endfunction

    // Drives one op in cycle 1 and a response schedule (cycle numbers, 0 = never),
    // recording what the DUT does; outputs are sampled 1 time unit after each negedge.
    task automatic mem_txn(input exec_data_t e, input int aok, input int dok, input int fl,
                           input logic [63:0] rdat, input int ncyc, output obs_t o);
        o.stall_cnt = 0; o.dreq_cnt = 0; o.out_cnt = 0; o.out_cyc = 0;
        o.err_cnt = 0; o.err_cyc = 0; o.held_ok = 1'b1; o.first_req = '0; o.outd = '0;
        @(negedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            in_valid      = (c == 1);
            dataE         = e;
            flush         = (c == fl);
            dresp.addr_ok = (c == aok);
            dresp.data_ok = (c == dok);
            dresp.data    = (c == dok) ? rdat : 64'h5A5A_5A5A_5A5A_5A5A;
            #1;
            if (stall) o.stall_cnt++;
            if (dreq.valid) begin
                if (o.dreq_cnt == 0) o.first_req = dreq;
                else if (dreq !== o.first_req) o.held_ok = 1'b0;
                o.dreq_cnt++;
            end
            if (out_valid) begin
                o.out_cnt++;
                o.outd    = dataM;
                o.out_cyc = c;
            end
            if (err_timeout) begin
                o.err_cnt++;
                if (o.err_cyc == 0) o.err_cyc = c;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        dresp    = '0;
        dataE    = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; dataE = '0; dresp = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || dataM !== '0 || stall !== 1'b0 || err_timeout !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs got ov=%b dataM=%h stall=%b err=%b exp 0", out_valid, dataM, stall, err_timeout);
        end
        tests++;
        if (dreq !== '0) begin
            fails++;
            $display("FAIL reset_dreq got %h exp 0", dreq);
        end
    endtask

    task automatic test_alu();
        int dreq_hi;
        dreq_hi = 0;
        @(negedge clk);
        in_valid = 1'b1;
        dataE    = mk(0, 0, 0, MSIZE8, 5'd5, 64'h1234, 64'hFFFF);
        #1;
        if (dreq.valid) dreq_hi++;
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL alu_stall got %b exp 0", stall);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        if (dreq.valid) dreq_hi++;
        tests++;
        if (out_valid !== 1'b1 || dataM.result !== 64'h1234 || dataM.dst !== 5'd5) begin
            fails++;
            $display("FAIL alu_result got ov=%b res=%h dst=%0d exp ov=1 res=1234 dst=5", out_valid, dataM.result, dataM.dst);
        end
        @(negedge clk);
        #1;
        if (dreq.valid) dreq_hi++;
        tests++;
        if (out_valid !== 1'b0 || dreq_hi != 0) begin
            fails++;
            $display("FAIL alu_one_shot got ov=%b dreq_hi=%0d exp ov=0 dreq_hi=0", out_valid, dreq_hi);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_valid = 1'b1;
        dataE    = mk(0, 0, 0, MSIZE8, 5'd1, 64'h1111, 64'd0);
        @(negedge clk);
        dataE    = mk(0, 0, 0, MSIZE8, 5'd2, 64'h2222, 64'd0);
        #1;
        tests++;
        if (out_valid !== 1'b1 || dataM.result !== 64'h1111) begin
            fails++;
            $display("FAIL b2b_first got ov=%b res=%h exp ov=1 res=1111", out_valid, dataM.result);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b1 || dataM.result !== 64'h2222 || dataM.dst !== 5'd2) begin
            fails++;
            $display("FAIL b2b_second got ov=%b res=%h dst=%0d exp ov=1 res=2222 dst=2", out_valid, dataM.result, dataM.dst);
        end
    endtask

    task automatic test_store_d();
        obs_t o;
        mem_txn(mk(0, 1, 0, MSIZE8, 5'd9, 64'h8000_0010, 64'h1122_3344_5566_7788), 2, 4, 0, 64'd0, 7, o);
        tests++;
        if (o.first_req.strobe !== 8'hFF || o.first_req.data !== 64'h1122_3344_5566_7788 ||
            o.first_req.addr !== 64'h8000_0010 || o.first_req.size !== MSIZE8) begin
            fails++;
            $display("FAIL sd_req got strobe=%h data=%h addr=%h exp strobe=ff data=1122334455667788 addr=80000010",
                     o.first_req.strobe, o.first_req.data, o.first_req.addr);
        end
        tests++;
        if (o.stall_cnt != 4 || o.dreq_cnt != 3 || o.held_ok !== 1'b1) begin
            fails++;
            $display("FAIL sd_timing got stall=%0d dreq=%0d held=%b exp stall=4 dreq=3 held=1", o.stall_cnt, o.dreq_cnt, o.held_ok);
        end
        tests++;
        if (o.out_cnt != 1 || o.out_cyc != 5 || o.outd.result !== 64'd0 || o.outd.dst !== 5'd0 || o.err_cnt != 0) begin
            fails++;
            $display("FAIL sd_output got cnt=%0d cyc=%0d res=%h dst=%0d err=%0d exp cnt=1 cyc=5 res=0 dst=0 err=0",
                     o.out_cnt, o.out_cyc, o.outd.result, o.outd.dst, o.err_cnt);
        end
    endtask

    task automatic test_store_b();
        obs_t o;
        mem_txn(mk(0, 1, 0, MSIZE1, 5'd0, 64'h8000_0005, 64'hAB), 2, 3, 0, 64'd0, 6, o);
        tests++;
        if (o.first_req.strobe !== 8'h20 || o.first_req.data !== 64'h0000_AB00_0000_0000) begin
            fails++;
            $display("FAIL sb_req got strobe=%h data=%h exp strobe=20 data=0000ab0000000000", o.first_req.strobe, o.first_req.data);
        end
        tests++;
        if (o.out_cnt != 1 || o.out_cyc != 4) begin
            fails++;
            $display("FAIL sb_output got cnt=%0d cyc=%0d exp cnt=1 cyc=4", o.out_cnt, o.out_cyc);
        end
    endtask

    task automatic test_loads();
        obs_t o;
        mem_txn(mk(1, 0, 0, MSIZE1, 5'd7, 64'h8000_0003, 64'd0), 2, 3, 0, 64'h0000_0000_8000_0000, 6, o);
        tests++;
        if (o.out_cnt != 1 || o.outd.result !== 64'hFFFF_FFFF_FFFF_FF80 || o.outd.dst !== 5'd7) begin
            fails++;
            $display("FAIL lb_result got cnt=%0d res=%h dst=%0d exp cnt=1 res=ffffffffffffff80 dst=7", o.out_cnt, o.outd.result, o.outd.dst);
        end
        tests++;
        if (o.first_req.strobe !== 8'h00 || o.first_req.size !== MSIZE1 || o.first_req.addr !== 64'h8000_0003) begin
            fails++;
            $display("FAIL lb_req got strobe=%h addr=%h exp strobe=00 addr=80000003", o.first_req.strobe, o.first_req.addr);
        end
        mem_txn(mk(1, 0, 1, MSIZE1, 5'd7, 64'h8000_0003, 64'd0), 2, 3, 0, 64'h0000_0000_8000_0000, 6, o);
        tests++;
        if (o.outd.result !== 64'h80) begin
            fails++;
            $display("FAIL lbu_result got %h exp 80", o.outd.result);
        end
        mem_txn(mk(1, 0, 0, MSIZE4, 5'd3, 64'h8000_0004, 64'd0), 2, 3, 0, 64'h89AB_CDEF_0000_0000, 6, o);
        tests++;
        if (o.outd.result !== 64'hFFFF_FFFF_89AB_CDEF) begin
            fails++;
            $display("FAIL lw_result got %h exp ffffffff89abcdef", o.outd.result);
        end
        mem_txn(mk(1, 0, 1, MSIZE2, 5'd4, 64'h8000_0006, 64'd0), 2, 3, 0, 64'hBEEF_0000_0000_0000, 6, o);
        tests++;
        if (o.outd.result !== 64'hBEEF) begin
            fails++;
            $display("FAIL lhu_result got %h exp beef", o.outd.result);
        end
    endtask

    task automatic test_misalign();
        obs_t o;
        mem_txn(mk(1, 0, 0, MSIZE4, 5'd6, 64'h8000_0002, 64'd0), 0, 0, 0, 64'd0, 4, o);
        tests++;
        if (o.dreq_cnt != 0 || o.stall_cnt != 0) begin
            fails++;
            $display("FAIL misalign_noreq got dreq=%0d stall=%0d exp 0 0", o.dreq_cnt, o.stall_cnt);
        end
        tests++;
        if (o.out_cnt != 1 || o.out_cyc != 2 || o.outd.ctl.misalign !== 1'b1 || o.outd.result !== 64'd0) begin
            fails++;
            $display("FAIL misalign_out got cnt=%0d cyc=%0d mis=%b res=%h exp cnt=1 cyc=2 mis=1 res=0",
                     o.out_cnt, o.out_cyc, o.outd.ctl.misalign, o.outd.result);
        end
    endtask

    task automatic test_same_cycle();
        obs_t o;
        mem_txn(mk(1, 0, 0, MSIZE8, 5'd8, 64'h8000_0008, 64'd0), 2, 2, 0, 64'h0123_4567_89AB_CDEF, 5, o);
        tests++;
        if (o.out_cnt != 1 || o.out_cyc != 3 || o.stall_cnt != 2 || o.dreq_cnt != 1 || o.outd.result !== 64'h0123_4567_89AB_CDEF) begin
            fails++;
            $display("FAIL same_cycle got cnt=%0d cyc=%0d stall=%0d dreq=%0d res=%h exp 1 3 2 1 0123456789abcdef",
                     o.out_cnt, o.out_cyc, o.stall_cnt, o.dreq_cnt, o.outd.result);
        end
    endtask

    task automatic test_flush();
        obs_t o;
        mem_txn(mk(0, 1, 0, MSIZE8, 5'd0, 64'h8000_0020, 64'h55), 0, 0, 2, 64'd0, 5, o);
        tests++;
        if (o.dreq_cnt != 1 || o.out_cnt != 0 || o.stall_cnt != 2) begin
            fails++;
            $display("FAIL flush_req got dreq=%0d out=%0d stall=%0d exp 1 0 2", o.dreq_cnt, o.out_cnt, o.stall_cnt);
        end
        mem_txn(mk(1, 0, 0, MSIZE8, 5'd2, 64'h8000_0028, 64'd0), 2, 4, 3, 64'h77, 6, o);
        tests++;
        if (o.dreq_cnt != 3 || o.out_cnt != 0 || o.held_ok !== 1'b1) begin
            fails++;
            $display("FAIL flush_wait got dreq=%0d out=%0d held=%b exp 3 0 1", o.dreq_cnt, o.out_cnt, o.held_ok);
        end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        in_valid = 1'b1;
        dataE    = mk(1, 0, 0, MSIZE8, 5'd3, 64'h8000_0030, 64'd0);
        @(negedge clk);
        in_valid      = 1'b0;
        dresp.addr_ok = 1'b1;
        @(negedge clk);
        dresp.addr_ok = 1'b0;
        reset         = 1'b1;
        #1;
        tests++;
        if (dreq.valid !== 1'b1) begin
            fails++;
            $display("FAIL rst_wait_pre got valid=%b exp 1", dreq.valid);
        end
        @(negedge clk);
        reset         = 1'b0;
        dresp.data_ok = 1'b1;
        dresp.data    = 64'h99;
        #1;
        tests++;
        if (dreq !== '0 || stall !== 1'b0) begin
            fails++;
            $display("FAIL rst_wait_idle got dreq=%h stall=%b exp 0 0", dreq, stall);
        end
        @(negedge clk);
        dresp = '0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || dreq.valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_wait_late got ov=%b valid=%b exp 0 0", out_valid, dreq.valid);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        mem_txn(mk(1, 0, 0, MSIZE8, 5'd11, 64'h8000_0100, 64'd0), 2, 14, 0, 64'hCAFE_F00D_0000_0001, 17, o);
        tests++;
        if (o.err_cnt != 1 || o.err_cyc != 10) begin
            fails++;
            $display("FAIL timeout_pulse got cnt=%0d cyc=%0d exp cnt=1 cyc=10", o.err_cnt, o.err_cyc);
        end
        tests++;
        if (o.out_cnt != 1 || o.out_cyc != 15 || o.outd.result !== 64'hCAFE_F00D_0000_0001 || o.held_ok !== 1'b1 || o.dreq_cnt != 13) begin
            fails++;
            $display("FAIL timeout_complete got cnt=%0d cyc=%0d res=%h held=%b dreq=%0d exp 1 15 cafef00d00000001 1 13",
                     o.out_cnt, o.out_cyc, o.outd.result, o.held_ok, o.dreq_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_store_d();
        test_store_b();
        test_loads();
        test_misalign();
        test_same_cycle();
        test_flush();
        test_reset_in_wait();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
